// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the MIPS instruction fetch/classify slice:
//   - DW                     : instruction word width
//   - OPC_MSB/OPC_LSB        : opcode field slice
//   - OPC_RTYPE/OPC_J/OPC_JAL: opcode values used by the classifier
//   - RD_MSB/RD_LSB          : destination register field slice
//   - fetch_state_e          : streamer state (IDLE, RUN, DONE)
//   - is_nop()               : detects the all-zero word (sll $0,$0,0)
// -----------------------------------------------------------------------------
package instr_pkg;

  localparam int DW = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // The canonical MIPS NOP encodes as an all-zero word.
  function automatic logic is_nop(input logic [DW-1:0] word);
    return (word == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/instr_stream_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_stream_fetch_if
// Bundles the program-load port, the start/len control, the valid/ready
// instruction stream and the status outputs of instr_stream_fetch.
//   slave  : view of the fetch block (drives stream + status)
//   master : view of the environment (drives load/start/ready)
// Signals:
//   load_we/load_addr/load_data : program-memory write port
//   start/len                   : stream request, len in 0..DEPTH
//   out_valid/out_ready         : stream handshake
//   out_instr/out_pc/out_last   : delivered word, its index, end marker
//   busy/done/count             : status
// -----------------------------------------------------------------------------
interface instr_stream_fetch_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) ();

  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic [AW:0]   len;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  modport slave (
    input  load_we, load_addr, load_data, start, len, out_ready,
    output out_valid, out_instr, out_pc, out_last, busy, done, count
  );

  modport master (
    output load_we, load_addr, load_data, start, len, out_ready,
    input  out_valid, out_instr, out_pc, out_last, busy, done, count
  );

endinterface

// File: rtl/instr_stream_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// DEPTH x DW program register file, one synchronous write port and one
// combinational read port. Contents are never reset.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (write-through when writing the addressed word)
// -----------------------------------------------------------------------------
module instr_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Program storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through lets a word written on the start edge be captured by that
  // same edge, so the write is seen to commit before streaming begins.
  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/instr_stream_fetch.sv
// -----------------------------------------------------------------------------
// instr_stream_fetch
// Streams words 0..len-1 of a writable program memory over a valid/ready
// handshake, one word per cycle when not back-pressured.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_stream_fetch_if.slave (load port, start/len, stream, status)
// Configuration:
//   HALT_ON_NOP_EN : when defined, an all-zero word ends the stream and is
//                    never presented; undefined, zero words stream normally.
// -----------------------------------------------------------------------------
module instr_stream_fetch
  import instr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = instr_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_stream_fetch_if.slave   bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  fetch_state_e  r_state, w_state_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic [DW-1:0] r_out_instr, w_out_instr_nxt;
  logic [AW-1:0] r_out_pc, w_out_pc_nxt;
  logic          r_out_last, w_out_last_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic [AW:0]   r_len_q, w_len_q_nxt;
  logic          r_busy, r_done;

  logic          w_mem_we;
  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_rd_data;
  logic          w_rd_is_nop;
  logic [AW:0]   w_len_clamped;
  logic          w_transfer;
  logic          w_next_last;

  // The program is frozen while a stream is in flight.
  assign w_mem_we      = bus.load_we && (r_state != RUN);
  assign w_len_clamped = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
  assign w_transfer    = r_out_valid && bus.out_ready;
  // Outside RUN the read port looks at word 0 so a start can load it directly;
  // in RUN it prefetches the word after the one being presented.
  assign w_rd_addr     = (r_state == RUN) ? (r_out_pc + AW'(1)) : AW'(0);
  assign w_next_last   = (({1'b0, r_out_pc} + (AW+1)'(2)) == r_len_q);

`ifdef HALT_ON_NOP_EN
  assign w_rd_is_nop = is_nop(w_rd_data);
`else
  assign w_rd_is_nop = 1'b0;
`endif

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Next-state and next-output computation for the stream FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    w_out_last_nxt  = r_out_last;
    w_count_nxt     = r_count;
    w_len_q_nxt     = r_len_q;

    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_count_nxt = (AW+1)'(0);
          w_len_q_nxt = w_len_clamped;
          if ((w_len_clamped == (AW+1)'(0)) || w_rd_is_nop) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt     = RUN;
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = w_rd_data;
            w_out_pc_nxt    = AW'(0);
            w_out_last_nxt  = (w_len_clamped == (AW+1)'(1));
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      RUN: begin
        if (w_transfer) begin
          w_count_nxt = r_count + (AW+1)'(1);
          // A following NOP ends the stream without ever being presented.
          if (r_out_last || w_rd_is_nop) begin
            w_state_nxt     = DONE;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_out_pc_nxt    = r_out_pc + AW'(1);
            w_out_instr_nxt = w_rd_data;
            w_out_last_nxt  = w_next_last;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
      end
    endcase
  end

  // State, stream output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= {DW{1'b0}};
      r_out_pc    <= {AW{1'b0}};
      r_out_last  <= 1'b0;
      r_count     <= {(AW+1){1'b0}};
      r_len_q     <= {(AW+1){1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_last  <= w_out_last_nxt;
      r_count     <= w_count_nxt;
      r_len_q     <= w_len_q_nxt;
      r_busy      <= (w_state_nxt == RUN);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_last  = r_out_last;
  assign bus.count     = r_count;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_instr_stream_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_stream_fetch
// Scoreboard bench: each start pushes the expected beats (computed from a
// shadow copy of the program) into a queue; a negedge monitor pops and
// compares on every handshake and checks that a stalled beat holds stable.
// -----------------------------------------------------------------------------
module tb_instr_stream_fetch;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  instr_stream_fetch_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  instr_stream_fetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t         sb_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;
  int            exp_count = 0;
  bit            rdy_random = 1'b0;
  bit            rdy_pat_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: scripted pattern first, then random or constantly high.
  always @(posedge clk) begin
    #1;
    if (rdy_pat_q.size() > 0) bus.out_ready = rdy_pat_q.pop_front();
    else if (rdy_random) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = 1'b1;
  end

  // Monitor: score every handshake, verify stalled beats stay put.
  bit    hold_arm = 1'b0;
  beat_t hold_b;
  beat_t mon_exp;
  beat_t mon_act;
  always @(negedge clk) begin
    mon_act = '{instr: bus.out_instr, pc: bus.out_pc, last: bus.out_last};
    if (!rst_n) begin
      hold_arm = 1'b0;
    end else begin
      if (hold_arm && bus.out_valid) check("hold_beat", 64'(mon_act), 64'(hold_b));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got pc %0d instr %h, expected no beat", bus.out_pc, bus.out_instr);
        end else begin
          mon_exp = sb_q.pop_front();
          check("beat", 64'(mon_act), 64'(mon_exp));
        end
        hold_arm = 1'b0;
      end else if (bus.out_valid) begin
        hold_arm = 1'b1;
        hold_b   = mon_act;
      end else begin
        hold_arm = 1'b0;
      end
    end
  end

  // Reference: stream is words 0..min(len,DEPTH)-1 in order, optionally cut
  // at the first zero word.
  task automatic push_expected(input int len_req);
    int    n;
    beat_t b;
    n = (len_req > DEPTH) ? DEPTH : len_req;
    exp_count = 0;
    for (int i = 0; i < n; i++) begin
`ifdef HALT_ON_NOP_EN
      if (model_mem[i] == 32'h0000_0000) break;
`endif
      b.instr = model_mem[i];
      b.pc    = AW'(i);
      b.last  = (i == n - 1);
      sb_q.push_back(b);
      exp_count++;
    end
  endtask

  task automatic wr_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.load_we = 1'b1; bus.load_addr = a; bus.load_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    bus.load_we = 1'b0;
  endtask

  task automatic issue_start(input int l, input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (wr) model_mem[wa] = wd;
    bus.load_we = wr; bus.load_addr = wa; bus.load_data = wd;
    bus.start = 1'b1; bus.len = (AW+1)'(l);
    push_expected(l);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.load_we = 1'b0;
    if (exp_count > 0) begin
      check("start_latency_valid", 64'(bus.out_valid), 64'(1));
      check("start_busy", 64'(bus.busy), 64'(1));
    end else begin
      check("empty_done", 64'(bus.done), 64'(1));
      check("empty_no_valid", 64'(bus.out_valid), 64'(0));
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!bus.done && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("done_reached", 64'(bus.done), 64'(1));
    check("count", 64'(bus.count), 64'(exp_count));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("busy_low", 64'(bus.busy), 64'(0));
  endtask

  int cyc;
  int guard;

  initial begin
    bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.len = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_instr", 64'(bus.out_instr), 64'(0));
    check("rst_pc",    64'(bus.out_pc),    64'(0));
    check("rst_last",  64'(bus.out_last),  64'(0));
    check("rst_busy",  64'(bus.busy),      64'(0));
    check("rst_done",  64'(bus.done),      64'(0));
    check("rst_count", 64'(bus.count),     64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr_mem(AW'(i), 32'h1000_0000 + 32'(i));

    // Basic program, ready held high: four beats back to back.
    wr_mem(3'd0, 32'h2004_0000);
    wr_mem(3'd1, 32'h0085_1820);
    wr_mem(3'd2, 32'h0800_0000);
    wr_mem(3'd3, 32'h0c00_0000);
    issue_start(4, 1'b0, '0, '0);
    wait_done(20, cyc);
    check("zero_bubble_cycles", 64'(cyc), 64'(4));

    // Same program with back-pressure pattern.
    rdy_pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    issue_start(4, 1'b0, '0, '0);
    wait_done(40, cyc);

    // Empty stream, then the full memory with no wrap.
    issue_start(0, 1'b0, '0, '0);
    wait_done(5, cyc);
    for (int i = 0; i < DEPTH; i++) wr_mem(AW'(i), $urandom | 32'h0000_0001);
    issue_start(8, 1'b0, '0, '0);
    wait_done(20, cyc);
    check("full_len_cycles", 64'(cyc), 64'(8));

    // Write and start during RUN are ignored; a later write is honoured.
    issue_start(4, 1'b0, '0, '0);
    bus.load_we = 1'b1; bus.load_addr = 3'd2; bus.load_data = 32'hDEAD_BEEF;
    bus.start = 1'b1; bus.len = 4'd1;
    @(posedge clk); #1;
    bus.load_we = 1'b0; bus.start = 1'b0;
    wait_done(20, cyc);
    wr_mem(3'd2, 32'hDEAD_BEEF);
    issue_start(4, 1'b0, '0, '0);
    wait_done(20, cyc);

    // Simultaneous start and write to word 0: the write is streamed.
    issue_start(3, 1'b1, 3'd0, 32'h1234_5678);
    wait_done(20, cyc);

    // Oversized len clamps to DEPTH.
    issue_start(13, 1'b0, '0, '0);
    wait_done(20, cyc);

    // Reset in the middle of a stream.
    issue_start(8, 1'b0, '0, '0);
    guard = 0;
    while (!(bus.out_valid && bus.out_pc == 3'd2) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_pc2", 64'(bus.out_pc), 64'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_instr", 64'(bus.out_instr), 64'(0));
    check("mid_rst_pc",    64'(bus.out_pc),    64'(0));
    check("mid_rst_last",  64'(bus.out_last),  64'(0));
    check("mid_rst_count", 64'(bus.count),     64'(0));
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    check("post_rst_done", 64'(bus.done), 64'(0));
    issue_start(8, 1'b0, '0, '0);
    wait_done(20, cyc);

`ifdef HALT_ON_NOP_EN
    // A zero word terminates the stream before it is presented.
    wr_mem(3'd0, 32'hAAAA_0001);
    wr_mem(3'd1, 32'hBBBB_0002);
    wr_mem(3'd2, 32'h0000_0000);
    wr_mem(3'd3, 32'hCCCC_0003);
    issue_start(4, 1'b0, '0, '0);
    wait_done(20, cyc);
    check("nop_count", 64'(bus.count), 64'(2));
`endif

    // Randomized programs, lengths and back-pressure.
    rdy_random = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        wr_mem(AW'($urandom_range(0, DEPTH - 1)),
               ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom);
      end
      if ($urandom_range(0, 3) == 0)
        issue_start(int'($urandom_range(0, 15)), 1'b1, 3'd0, $urandom);
      else
        issue_start(int'($urandom_range(0, 15)), 1'b0, '0, '0);
      wait_done(200, cyc);
    end
    rdy_random = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
